// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: multi-cycle sequencer between execute and the CSR file.
// Performs CSRRW/CSRRS/CSRRC read-modify-write, ECALL trap entry, MRET
// trap return and EBREAK halt, returning old CSR value / PC redirect.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low; the controller holds its response stable likewise.
module csr_access_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 32'h0000000b,
  parameter logic [11:0]     MTVEC_ADDR  = 12'h305,
  parameter logic [11:0]     MEPC_ADDR   = 12'h341,
  parameter logic [11:0]     MCAUSE_ADDR = 12'h342
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [11:0]     in_csr_addr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic            in_rs1_zero,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_npc,
  output logic            out_halt,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_EPC   = 3'd3,
    S_CAUSE = 3'd4,
    S_VEC   = 3'd5,
    S_RESP  = 3'd6
  } state_e;

  localparam logic [2:0] OP_MRET   = 3'b001;
  localparam logic [2:0] OP_ECALL  = 3'b010;
  localparam logic [2:0] OP_EBREAK = 3'b011;
  localparam logic [2:0] OP_CSRRW  = 3'b100;
  localparam logic [2:0] OP_CSRRS  = 3'b101;
  localparam logic [2:0] OP_CSRRC  = 3'b110;

  // mtvec low two bits are the mode field, never part of the target
  localparam logic [XLEN-1:0] VEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            rs1z_q, rs1z_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            halt_q, halt_d;
  logic [XLEN-1:0] rmw_val;

  assign out_rdata    = rdata_q;
  assign out_redirect = redirect_q;
  assign out_npc      = npc_q;
  assign out_halt     = halt_q;
  assign dbg_state    = state_q;

  // state and latched request/response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      rs1_q      <= '0;
      rs1z_q     <= 1'b0;
      pc_q       <= '0;
      old_q      <= '0;
      rdata_q    <= '0;
      redirect_q <= 1'b0;
      npc_q      <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rs1_q      <= rs1_d;
      rs1z_q     <= rs1z_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
      rdata_q    <= rdata_d;
      redirect_q <= redirect_d;
      npc_q      <= npc_d;
      halt_q     <= halt_d;
    end
  end

  // new CSR value for the read-modify-write ops
  always_comb begin
    rmw_val = rs1_q;
    case (op_q)
      OP_CSRRS: rmw_val = old_q | rs1_q;
      OP_CSRRC: rmw_val = old_q & ~rs1_q;
      default:  rmw_val = rs1_q;
    endcase
  end

  // next-state, CSR port drive and response updates
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rs1_d      = rs1_q;
    rs1z_d     = rs1z_q;
    pc_d       = pc_q;
    old_d      = old_q;
    rdata_d    = rdata_q;
    redirect_d = redirect_q;
    npc_d      = npc_q;
    halt_d     = halt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    csr_raddr  = '0;
    csr_wen    = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d       = in_op;
          addr_d     = in_csr_addr;
          rs1_d      = in_rs1;
          rs1z_d     = in_rs1_zero;
          pc_d       = in_pc;
          rdata_d    = '0;
          redirect_d = 1'b0;
          npc_d      = '0;
          halt_d     = 1'b0;
          case (in_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_READ;
            OP_ECALL:  state_d = S_EPC;
            OP_MRET:   state_d = S_VEC;
            OP_EBREAK: begin
              halt_d  = 1'b1;
              state_d = S_RESP;
            end
            default:   state_d = S_RESP;
          endcase
        end
      end
      S_READ: begin
        csr_raddr = addr_q;
        old_d     = csr_rdata;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        csr_waddr = addr_q;
        csr_wdata = rmw_val;
        // set/clear with rs1=x0 is a pure read: no write side effect
        csr_wen   = !(rs1z_q && (op_q != OP_CSRRW));
        rdata_d   = old_q;
        state_d   = S_RESP;
      end
      S_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = MEPC_ADDR;
        csr_wdata = pc_q;
        state_d   = S_CAUSE;
      end
      S_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = MCAUSE_ADDR;
        csr_wdata = ECALL_CAUSE;
        state_d   = S_VEC;
      end
      S_VEC: begin
        redirect_d = 1'b1;
        if (op_q == OP_ECALL) begin
          csr_raddr = MTVEC_ADDR;
          npc_d     = csr_rdata & VEC_MASK;
        end else begin
          csr_raddr = MEPC_ADDR;
          npc_d     = csr_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          redirect_d = 1'b0;
          halt_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a flat CSR-file model drives
// csr_rdata, a transaction-level reference predicts writes/reads/responses.
module tb_csr_access_ctrl;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [11:0] in_csr_addr;
  logic [31:0] in_rs1;
  logic        in_rs1_zero;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_redirect;
  logic [31:0] out_npc;
  logic        out_halt;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [2:0]  dbg_state;

  csr_access_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_csr_addr(in_csr_addr), .in_rs1(in_rs1), .in_rs1_zero(in_rs1_zero),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_redirect(out_redirect), .out_npc(out_npc),
    .out_halt(out_halt), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [31:0] cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // CSR file seen by the DUT: combinational read, write on rising edge
  logic [31:0] csr_file [0:4095];
  assign csr_rdata = csr_file[csr_raddr];
  always @(posedge clock) if (csr_wen) csr_file[csr_waddr] <= csr_wdata;

  int ready_mode = 2;  // 0 random, 1 hold low, 2 always high
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] due;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] npc;
    logic        halt;
  } resp_t;

  logic [75:0] exp_q[$];   // expected writes {cycle, addr, data}
  logic [43:0] rd_q[$];    // expected reads  {cycle, addr}
  resp_t       resp_q[$];
  logic [31:0] model_csr [0:4095];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // observations recorded for the directed literal checks
  int          wen_count = 0;
  logic [11:0] last_waddr, prev_waddr;
  logic [31:0] last_wdata, prev_wdata, last_wcyc, prev_wcyc;
  logic [31:0] last_rdata, last_npc, first_valid_cyc, acc_cyc;
  logic        last_redir, last_halt, prev_ov = 1'b0;

  // per-cycle compare against the model
  always @(negedge clock) begin
    logic        ev, ew;
    logic [11:0] er;
    if (!reset) begin
      ew = (exp_q.size() > 0) && (exp_q[0][75:44] == cyc);
      check("csr_wen", csr_wen, ew);
      if (ew) begin
        check("csr_waddr", csr_waddr, exp_q[0][43:32]);
        check("csr_wdata", csr_wdata, exp_q[0][31:0]);
        model_csr[exp_q[0][43:32]] = exp_q[0][31:0];
        void'(exp_q.pop_front());
      end
      if (csr_wen) begin
        wen_count++;
        prev_waddr = last_waddr; prev_wdata = last_wdata; prev_wcyc = last_wcyc;
        last_waddr = csr_waddr;  last_wdata = csr_wdata;  last_wcyc = cyc;
      end
      er = 12'h000;
      if ((rd_q.size() > 0) && (rd_q[0][43:12] == cyc)) begin
        er = rd_q[0][11:0];
        void'(rd_q.pop_front());
      end
      check("csr_raddr", csr_raddr, er);
      check("in_ready", in_ready, resp_q.size() == 0);
      ev = (resp_q.size() > 0) && (cyc >= resp_q[0].due);
      check("out_valid", out_valid, ev);
      if (out_valid && !prev_ov) first_valid_cyc = cyc;
      prev_ov = out_valid;
      if (ev) begin
        check("out_rdata", out_rdata, resp_q[0].rdata);
        check("out_redirect", out_redirect, resp_q[0].redir);
        check("out_npc", out_npc, resp_q[0].npc);
        check("out_halt", out_halt, resp_q[0].halt);
        if (out_ready) begin
          last_rdata = out_rdata; last_npc = out_npc;
          last_redir = out_redirect; last_halt = out_halt;
          void'(resp_q.pop_front());
        end
      end
    end else begin
      prev_ov = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_resp(input logic [31:0] due, input logic [31:0] rd,
                           input logic rdr, input logic [31:0] npc, input logic h);
    resp_t r;
    r.due = due; r.rdata = rd; r.redir = rdr; r.npc = npc; r.halt = h;
    resp_q.push_back(r);
  endtask

  task automatic flush_model();
    exp_q.delete();
    rd_q.delete();
    resp_q.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                      input logic rz, input logic [31:0] pc);
    logic rdy;
    int budget;
    logic [31:0] old, nv;
    in_valid = 1'b1; in_op = op; in_csr_addr = addr;
    in_rs1 = rs1; in_rs1_zero = rz; in_pc = pc;
    rdy = 1'b0;
    budget = 0;
    while (!rdy && budget < 100) begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      timeout_fail("accept");
      return;
    end
    acc_cyc = cyc;
    case (op)
      3'b100, 3'b101, 3'b110: begin
        old = model_csr[addr];
        if (op == 3'b100)      nv = rs1;
        else if (op == 3'b101) nv = old | rs1;
        else                   nv = old & ~rs1;
        rd_q.push_back({acc_cyc, addr});
        if (!(rz && op != 3'b100)) exp_q.push_back({acc_cyc + 1, addr, nv});
        push_resp(acc_cyc + 2, old, 1'b0, 32'h0, 1'b0);
      end
      3'b010: begin
        exp_q.push_back({acc_cyc, 12'h341, pc});
        exp_q.push_back({acc_cyc + 1, 12'h342, 32'h0000000b});
        rd_q.push_back({acc_cyc + 2, 12'h305});
        push_resp(acc_cyc + 3, 32'h0, 1'b1, model_csr[12'h305] & 32'hffff_fffc, 1'b0);
      end
      3'b001: begin
        rd_q.push_back({acc_cyc, 12'h341});
        push_resp(acc_cyc + 1, 32'h0, 1'b1, model_csr[12'h341], 1'b0);
      end
      3'b011:  push_resp(acc_cyc, 32'h0, 1'b0, 32'h0, 1'b1);
      default: push_resp(acc_cyc, 32'h0, 1'b0, 32'h0, 1'b0);
    endcase
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (resp_q.size() != 0 && b < 80) begin
      @(posedge clock);
      #3;
      b++;
    end
    if (resp_q.size() != 0) begin
      timeout_fail("response");
      flush_model();
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    logic [11:0] ra;
    reset = 1'b1;
    in_valid = 1'b0; in_op = 3'b000; in_csr_addr = 12'h0;
    in_rs1 = 32'h0; in_rs1_zero = 1'b0; in_pc = 32'h0;
    for (int i = 0; i < 4096; i++) begin
      csr_file[i] = 32'h0;
      model_csr[i] = 32'h0;
    end
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_csr_wen", csr_wen, 1'b0);
    check("rst_out_rdata", out_rdata, 32'h0);
    check("rst_out_npc", out_npc, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // CSRRW mtvec from zero
    w0 = wen_count;
    send(3'b100, 12'h305, 32'h80000100, 1'b0, 32'h0);
    wait_idle();
    check("t1_wen_pulses", wen_count - w0, 1);
    check("t1_waddr", last_waddr, 12'h305);
    check("t1_wdata", last_wdata, 32'h80000100);
    check("t1_rdata", last_rdata, 32'h0);
    check("t1_latency", first_valid_cyc - acc_cyc + 1, 3);

    // set mode bit -> mtvec = 0x80000102, then ECALL
    send(3'b101, 12'h305, 32'h2, 1'b0, 32'h0);
    wait_idle();
    check("t2_rdata", last_rdata, 32'h80000100);
    w0 = wen_count;
    send(3'b010, 12'h0, 32'h0, 1'b0, 32'h80000010);
    wait_idle();
    check("ecall_wen_pulses", wen_count - w0, 2);
    check("ecall_mepc_addr", prev_waddr, 12'h341);
    check("ecall_mepc_data", prev_wdata, 32'h80000010);
    check("ecall_cause_addr", last_waddr, 12'h342);
    check("ecall_cause_data", last_wdata, 32'h0000000b);
    check("ecall_consecutive", last_wcyc - prev_wcyc, 1);
    check("ecall_redirect", last_redir, 1'b1);
    check("ecall_npc", last_npc, 32'h80000100);
    check("ecall_latency", first_valid_cyc - acc_cyc + 1, 4);

    // MRET
    w0 = wen_count;
    send(3'b001, 12'h0, 32'h0, 1'b0, 32'h0);
    wait_idle();
    check("mret_wen_pulses", wen_count - w0, 0);
    check("mret_npc", last_npc, 32'h80000010);
    check("mret_redirect", last_redir, 1'b1);
    check("mret_latency", first_valid_cyc - acc_cyc + 1, 2);

    // CSRRS with rs1=x0, then CSRRC
    w0 = wen_count;
    send(3'b101, 12'h342, 32'hffff_ffff, 1'b1, 32'h0);
    wait_idle();
    check("csrrs_x0_wen", wen_count - w0, 0);
    check("csrrs_x0_rdata", last_rdata, 32'hb);
    send(3'b110, 12'h342, 32'h3, 1'b0, 32'h0);
    wait_idle();
    check("csrrc_wdata", last_wdata, 32'h8);
    check("csrrc_rdata", last_rdata, 32'hb);

    // response held under back-pressure
    ready_mode = 1;
    send(3'b011, 12'h0, 32'h0, 1'b0, 32'h0);
    check("ebreak_latency_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_halt", out_halt, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    ready_mode = 2;
    wait_idle();
    check("ebreak_halt", last_halt, 1'b1);

    // reset during the CAUSE write of an ECALL
    send(3'b010, 12'h0, 32'h0, 1'b0, 32'h80000200);
    @(posedge clock);
    #1;
    reset = 1'b1;
    flush_model();
    w0 = wen_count;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_csr_wen", csr_wen, 1'b0);
    check("midrst_csr_waddr", csr_waddr, 12'h0);
    check("midrst_csr_wdata", csr_wdata, 32'h0);
    check("midrst_out_npc", out_npc, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_mepc", csr_file[12'h341], 32'h80000200);
    check("midrst_mcause", csr_file[12'h342], 32'h8);
    @(posedge clock);
    #1;
    check("midrst_no_wen", wen_count - w0, 0);
    check("midrst_in_ready", in_ready, 1'b1);
    w0 = wen_count;
    send(3'b100, 12'h300, 32'h1888, 1'b0, 32'h0);
    wait_idle();
    check("post_rst_wen", wen_count - w0, 1);
    check("post_rst_wdata", last_wdata, 32'h1888);
    check("post_rst_rdata", last_rdata, 32'h0);

    // randomized traffic with random back-pressure
    ready_mode = 0;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0:       ra = 12'h300;
        1:       ra = 12'h305;
        2:       ra = 12'h341;
        3:       ra = 12'h342;
        default: ra = 12'($urandom_range(0, 4095));
      endcase
      send(3'($urandom_range(0, 7)), ra, $urandom, 1'($urandom_range(0, 1)), $urandom);
      wait_idle();
    end
    ready_mode = 2;
    repeat (3) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Multi-cycle sequencer between the execute stage and the single-read/single-write-port CSR file (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342).
- Accepts one system instruction at a time over a valid/ready handshake.
- Drives the CSR file's ports to perform each operation:
  - read-modify-write for CSRRW/CSRRS/CSRRC;
  - trap entry for ECALL;
  - trap return for MRET;
  - halt for EBREAK.
- Returns the old CSR value and any PC redirect to the write-back stage.

Parameters:
- XLEN, 32, datapath width.
- ECALL_CAUSE, 32'h0000000b, value written to mcause on ECALL.
- MTVEC_ADDR, 12'h305, mtvec address.
- MEPC_ADDR, 12'h341, mepc address.
- MCAUSE_ADDR, 12'h342, mcause address.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_op  in  3  001 MRET, 010 ECALL, 011 EBREAK, 100 CSRRW, 101 CSRRS, 110 CSRRC; 000/111 NOP.
- in_csr_addr  in  12  CSR address for CSRRx.
- in_rs1  in  XLEN  source operand.
- in_rs1_zero  in  1  rs1 field is x0; suppresses the write for CSRRS/CSRRC.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts the response.
- out_rdata  out  XLEN  old CSR value for rd; 0 for non-CSRRx ops.
- out_redirect  out  1  out_npc is valid (ECALL/MRET).
- out_npc  out  XLEN  redirect target.
- out_halt  out  1  EBREAK completed.
- csr_raddr  out  12  CSR read address; the CSR file returns data combinationally, same cycle.
- csr_rdata  in  XLEN  CSR read data.
- csr_wen  out  1  CSR write strobe, one cycle per write.
- csr_waddr  out  12  CSR write address.
- csr_wdata  out  XLEN  CSR write data.

Behaviour:
- Reset (asynchronous; can assert at any time, including mid-operation):
  - state=IDLE; all latched request fields and response registers cleared.
  - out_valid=0, out_rdata=0, out_redirect=0, out_npc=0, out_halt=0, csr_wen=0, csr_raddr=0, csr_waddr=0, csr_wdata=0.
  - An in-flight operation is abandoned; no partial write is issued after reset is released.
- States: IDLE, READ, WRITE, EPC, CAUSE, VEC, RESP.
- Accept:
  - in_ready = (state==IDLE), combinational.
  - A transfer occurs on a rising edge with in_valid && in_ready; op/addr/rs1/rs1_zero/pc are latched.
  - Transitions from IDLE on accept:
    - CSRRx -> READ
    - ECALL -> EPC
    - MRET -> VEC
    - EBREAK -> RESP with halt=1
    - NOP/unused opcodes -> RESP with all response fields 0
- READ:
  - csr_raddr = latched addr; csr_rdata captured into old.
  - Next state WRITE.
- WRITE:
  - csr_waddr = addr.
  - csr_wdata:
    - CSRRW: rs1
    - CSRRS: old | rs1
    - CSRRC: old & ~rs1
  - csr_wen = 1, except CSRRS/CSRRC with rs1_zero=1, where csr_wen = 0.
  - Next state RESP with out_rdata = old.
- ECALL sequence:
  - EPC: csr_wen=1, waddr=MEPC_ADDR, wdata=pc.
  - CAUSE: csr_wen=1, waddr=MCAUSE_ADDR, wdata=ECALL_CAUSE.
  - VEC: raddr=MTVEC_ADDR, npc = csr_rdata & ~32'h3.
  - RESP with out_redirect=1.
- MRET sequence:
  - VEC: raddr=MEPC_ADDR, npc = csr_rdata (no masking).
  - RESP with out_redirect=1.
- RESP:
  - out_valid=1; response fields stable until out_valid && out_ready.
  - On that edge: state -> IDLE, out_valid/out_redirect/out_halt cleared.
  - A new request can be accepted no earlier than the cycle after the handshake; there is no bypass.
- Latency from accept edge to first out_valid cycle:
  - CSRRx: 3 cycles
  - ECALL: 4 cycles
  - MRET: 2 cycles
  - EBREAK/NOP: 1 cycle
- csr_wen is 0 in every state other than WRITE/EPC/CAUSE.
- csr_raddr = 0 outside READ/VEC.
- Unimplemented CSR addresses are forwarded unchanged; mapping and read-as-zero are the CSR file's responsibility.
- Arithmetic is XLEN-bit with no carries.

Test Plan:
- Reset, then CSRRW addr 0x305 rs1=0x80000100 (CSR holds 0x0) -> exactly one csr_wen pulse (0x305, 0x80000100); out_rdata=0; out_valid 3 cycles after accept.
- mtvec=0x80000102, ECALL pc=0x80000010 -> writes mepc=0x80000010 then mcause=0xb on consecutive cycles; out_redirect=1, out_npc=0x80000100.
- mepc=0x80000010, MRET -> no csr_wen; out_npc=0x80000010, out_redirect=1 after 2 cycles.
- CSRRS addr 0x342 with rs1_zero=1, CSR=0xb -> csr_wen never asserted; out_rdata=0xb. CSRRC rs1=0x3 on CSR 0xb -> wdata=0x8.
- Hold out_ready=0 for 5 cycles in RESP -> out_valid and out_* stable, in_ready=0; accept occurs only after the handshake.
- Assert reset during the CAUSE state of an ECALL -> outputs zero immediately; no further csr_wen; after release in_ready=1 and the next CSRRW completes normally.
